// File: rtl/bp_cce_pending_table.sv
// bp_cce_pending_table
//   Address-indexed table of saturating pending-transaction counters.
//   After reset an init sweep zeroes every entry; operations are accepted
//   only once ready_o is high. Reads are registered with write-to-read
//   forwarding when both target the same index in the same cycle.
//   Optional feature macro: BP_CCE_PENDING_TABLE_ERR_EN enables the sticky
//   overflow/underflow flags; without it the flags are tied to 0.
//
//   Handshake: w_v_i / r_v_i are single-cycle valid strobes with no ready
//   handshake per operation; they are honoured only while ready_o is high and
//   silently dropped otherwise. pending_v_o pulses for exactly one cycle per
//   accepted read, one cycle after the request.
module bp_cce_pending_table #(
    parameter int paddr_width_p         = 40,
    parameter int block_size_in_bytes_p = 64,
    parameter int num_entries_p         = 64,
    parameter int cnt_width_p           = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    output logic                   ready_o,
    input  logic                   w_v_i,
    input  logic [paddr_width_p-1:0] w_addr_i,
    input  logic                   w_inc_i,
    input  logic                   w_clear_i,
    input  logic                   r_v_i,
    input  logic [paddr_width_p-1:0] r_addr_i,
    output logic                   pending_v_o,
    output logic                   pending_o,
    output logic [cnt_width_p-1:0] count_o,
    output logic                   err_overflow_o,
    output logic                   err_underflow_o
);

    localparam int lg_blk_lp = $clog2(block_size_in_bytes_p);
    localparam int lg_n_lp   = $clog2(num_entries_p);
    localparam logic [lg_n_lp-1:0]     last_idx_lp = lg_n_lp'(num_entries_p - 1);
    localparam logic [cnt_width_p-1:0] cnt_max_lp  = '1;

    typedef enum logic {e_init, e_ready} state_e;

    state_e                 state_r, state_n;
    logic [lg_n_lp-1:0]     init_ptr_r;
    logic [cnt_width_p-1:0] mem_r [num_entries_p];

    logic [lg_n_lp-1:0]     w_idx, r_idx;
    logic                   w_acc, r_acc;
    logic [cnt_width_p-1:0] w_cur, w_next, r_data;

    // Only the index field of each address is meaningful; the rest folds here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr_i, r_addr_i};

    assign w_idx = w_addr_i[lg_blk_lp +: lg_n_lp];
    assign r_idx = r_addr_i[lg_blk_lp +: lg_n_lp];
    assign w_acc = w_v_i & ready_o;
    assign r_acc = r_v_i & ready_o;
    assign w_cur = mem_r[w_idx];

    // FSM state register: any reset cycle restarts the init sweep.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_r <= e_init;
        else            state_r <= state_n;
    end

    // FSM next state: leave init once the last entry has been zeroed.
    always_comb begin
        state_n = state_r;
        if (state_r == e_init && init_ptr_r == last_idx_lp) state_n = e_ready;
    end

    // FSM outputs.
    always_comb begin
        ready_o = (state_r == e_ready);
    end

    // Init pointer walks one entry per cycle while sweeping.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i)              init_ptr_r <= '0;
        else if (state_r == e_init)  init_ptr_r <= init_ptr_r + 1'b1;
    end

    // Saturating update of the addressed counter; clear wins over inc/dec.
    always_comb begin
        w_next = w_cur;
        if (w_clear_i)                          w_next = '0;
        else if (w_inc_i && w_cur != cnt_max_lp) w_next = w_cur + 1'b1;
        else if (!w_inc_i && w_cur != '0)        w_next = w_cur - 1'b1;
    end

    // Counter array: zeroed by the sweep, otherwise updated by accepted writes.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (state_r == e_init) mem_r[init_ptr_r] <= '0;
            else if (w_acc)        mem_r[w_idx]      <= w_next;
        end
    end

    // Read data with same-cycle same-index forwarding of the post-write value.
    always_comb begin
        r_data = mem_r[r_idx];
        if (w_acc && w_idx == r_idx) r_data = w_next;
    end

    // Registered read result; data holds when no read is accepted.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pending_v_o <= 1'b0;
            pending_o   <= 1'b0;
            count_o     <= '0;
        end else begin
            pending_v_o <= r_acc;
            if (r_acc) begin
                pending_o <= (r_data != '0);
                count_o   <= r_data;
            end
        end
    end

`ifdef BP_CCE_PENDING_TABLE_ERR_EN
    logic ovf_hit, unf_hit;
    logic err_ovf_r, err_unf_r;

    assign ovf_hit = w_acc & ~w_clear_i &  w_inc_i & (w_cur == cnt_max_lp);
    assign unf_hit = w_acc & ~w_clear_i & ~w_inc_i & (w_cur == '0);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else begin
            err_ovf_r <= err_ovf_r | ovf_hit;
            err_unf_r <= err_unf_r | unf_hit;
        end
    end

    assign err_overflow_o  = err_ovf_r;
    assign err_underflow_o = err_unf_r;
`else
    assign err_overflow_o  = 1'b0;
    assign err_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_pending_table.sv
// Directed testbench for bp_cce_pending_table (default parameters).
module tb_bp_cce_pending_table;

    localparam int AW = 40;
    localparam int CW = 4;
`ifdef BP_CCE_PENDING_TABLE_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          ready_o;
    logic          w_v_i;
    logic [AW-1:0] w_addr_i;
    logic          w_inc_i;
    logic          w_clear_i;
    logic          r_v_i;
    logic [AW-1:0] r_addr_i;
    logic          pending_v_o;
    logic          pending_o;
    logic [CW-1:0] count_o;
    logic          err_overflow_o;
    logic          err_underflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_cce_pending_table dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .ready_o         (ready_o),
        .w_v_i           (w_v_i),
        .w_addr_i        (w_addr_i),
        .w_inc_i         (w_inc_i),
        .w_clear_i       (w_clear_i),
        .r_v_i           (r_v_i),
        .r_addr_i        (r_addr_i),
        .pending_v_o     (pending_v_o),
        .pending_o       (pending_o),
        .count_o         (count_o),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_v_i = 1'b0; w_addr_i = '0; w_inc_i = 1'b0; w_clear_i = 1'b0;
        r_v_i = 1'b0; r_addr_i = '0;
    endtask

    // Counts cycles until ready_o rises (bounded) and compares against 64.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 200) begin
            step();
            n++;
        end
        check(tag, n, 64);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic inc, input logic clr);
        w_v_i = 1'b1; w_addr_i = a; w_inc_i = inc; w_clear_i = clr;
        step();
        w_v_i = 1'b0; w_clear_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] exp);
        r_v_i = 1'b1; r_addr_i = a;
        step();
        r_v_i = 1'b0;
        check({tag, "_v"}, pending_v_o, 1);
        check({tag, "_cnt"}, count_o, exp);
        check({tag, "_pend"}, pending_o, (exp != 0));
    endtask

    initial begin
        idle_inputs();
        reset_n_i = 1'b0;
        step(); step(); step();
        check("rst_ready", ready_o, 0);
        check("rst_pv", pending_v_o, 0);
        check("rst_pend", pending_o, 0);
        check("rst_cnt", count_o, 0);
        check("rst_ovf", err_overflow_o, 0);
        check("rst_unf", err_underflow_o, 0);

        // Init
        reset_n_i = 1'b1;
        wait_ready("init_cycles");
        read_check("init_rd0", 40'h0, 0);

        // Basic count plus aliasing
        do_write(40'h1040, 1'b1, 1'b0);
        do_write(40'h1040, 1'b1, 1'b0);
        do_write(40'h1040, 1'b0, 1'b0);
        read_check("basic_1040", 40'h1040, 1);
        read_check("basic_1000", 40'h1000, 0);
        read_check("alias_2040", 40'h2040, 1);
        // No read this cycle: pulse drops, data holds.
        step();
        check("pv_pulse", pending_v_o, 0);
        check("hold_cnt", count_o, 1);

        // Forwarding on a fresh entry
        w_v_i = 1'b1; w_addr_i = 40'h80; w_inc_i = 1'b1;
        r_v_i = 1'b1; r_addr_i = 40'h80;
        step();
        idle_inputs();
        check("fwd_v", pending_v_o, 1);
        check("fwd_cnt", count_o, 1);
        // Different indices in the same cycle are independent
        w_v_i = 1'b1; w_addr_i = 40'h80; w_inc_i = 1'b1;
        r_v_i = 1'b1; r_addr_i = 40'hC0;
        step();
        idle_inputs();
        check("indep_cnt", count_o, 0);
        read_check("indep_80", 40'h80, 2);

        // Back-to-back reads
        r_v_i = 1'b1; r_addr_i = 40'h80;
        step();
        check("b2b_a", count_o, 2);
        r_addr_i = 40'h1040;
        step();
        r_v_i = 1'b0;
        check("b2b_v", pending_v_o, 1);
        check("b2b_b", count_o, 1);

        // Saturation on entry 0
        for (int i = 0; i < 15; i++) do_write(40'h0, 1'b1, 1'b0);
        check("sat15_ovf", err_overflow_o, 0);
        read_check("sat15", 40'h0, 15);
        do_write(40'h0, 1'b1, 1'b0);
        check("sat16_ovf", err_overflow_o, ERR_ON);
        read_check("sat16", 40'h0, 15);

        // Underflow (0x40 is entry 1, cleared first) and clear
        do_write(40'h40, 1'b1, 1'b1);
        read_check("clr_40", 40'h40, 0);
        check("pre_unf", err_underflow_o, 0);
        do_write(40'h40, 1'b0, 1'b0);
        check("unf_flag", err_underflow_o, ERR_ON);
        read_check("unf_40", 40'h40, 0);
        do_write(40'h40, 1'b1, 1'b0);
        do_write(40'h40, 1'b1, 1'b0);
        do_write(40'h40, 1'b1, 1'b0);
        read_check("inc3_40", 40'h40, 3);
        do_write(40'h40, 1'b0, 1'b1);
        read_check("clr3_40", 40'h40, 0);

        // Reset mid-init
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("mid_ready", ready_o, 0);
        reset_n_i = 1'b0;
        step();
        check("mid_rst_ovf", err_overflow_o, 0);
        check("mid_rst_unf", err_underflow_o, 0);
        reset_n_i = 1'b1;
        // Operations during init must be ignored.
        w_v_i = 1'b1; w_addr_i = 40'h1040; w_inc_i = 1'b1;
        r_v_i = 1'b1; r_addr_i = 40'h1040;
        begin
            int n = 0;
            int pv_seen = 0;
            while (!ready_o && n < 200) begin
                step();
                n++;
                if (pending_v_o) pv_seen++;
                if (n == 60) begin
                    idle_inputs();
                end
            end
            check("reinit_cycles", n, 64);
            check("init_no_read", pv_seen, 0);
        end
        idle_inputs();
        read_check("after_reinit", 40'h1040, 0);
        read_check("after_reinit0", 40'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
